// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle between the four source front-ends, the round-robin
// arbiter and the downstream consumer of the shared 8-bit mux.
interface mux_rr_arbiter_if;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       active;
    logic [3:0] burst_cnt;

    // Source side: raises requests and last-beat flags, observes the grant.
    modport master (
        output req,
        output done,
        input  grant,
        input  sel,
        input  active,
        input  burst_cnt
    );

    // Arbiter side.
    modport slave (
        input  req,
        input  done,
        output grant,
        output sel,
        output active,
        output burst_cnt
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the select lines of the shared 4:1 data mux;
// grants are one-hot, bounded to MAX_BURST cycles, with a 1-cycle bubble between owners.
module mux_rr_arbiter #(
    parameter int MAX_BURST = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    mux_rr_arbiter_if.slave      bus
);

    if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_max_burst
        $fatal(1, "mux_rr_arbiter: MAX_BURST must be in 1..15");
    end

    typedef enum logic {
        IDLE,
        OWN
    } state_e;

    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

    state_e     state_q,     state_d;
    logic [1:0] ptr_q,       ptr_d;
    logic [3:0] grant_q,     grant_d;
    logic [1:0] sel_q,       sel_d;
    logic       active_q,    active_d;
    logic [3:0] burst_cnt_q, burst_cnt_d;

    logic       win_found;
    logic [1:0] win_idx;
    logic [1:0] cand;
    logic       release_own;

    // First requester at or after ptr, wrapping modulo 4.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign release_own = bus.done[sel_q] || !bus.req[sel_q] || (burst_cnt_q == BURST_LIMIT);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        sel_d       = sel_q;
        active_d    = active_q;
        burst_cnt_d = burst_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_d     = 4'b0001 << win_idx;
                    sel_d       = win_idx;
                    active_d    = 1'b1;
                    burst_cnt_d = 4'd1;
                    state_d     = OWN;
                end else begin
                    grant_d     = '0;
                    active_d    = 1'b0;
                    burst_cnt_d = '0;
                end
            end
            OWN: begin
                // sel keeps pointing at the last owner through the idle bubble.
                if (release_own) begin
                    grant_d     = '0;
                    active_d    = 1'b0;
                    burst_cnt_d = '0;
                    ptr_d       = sel_q + 2'd1;
                    state_d     = IDLE;
                end else begin
                    burst_cnt_d = burst_cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            sel_q       <= '0;
            active_q    <= 1'b0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            sel_q       <= sel_d;
            active_q    <= active_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.sel       = sel_q;
    assign bus.active    = active_q;
    assign bus.burst_cnt = burst_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(grant_q));
            assert (active_q == (|grant_q));
            assert (!active_q || grant_q[sel_q]);
            assert (burst_cnt_q <= BURST_LIMIT);
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed-vector bench for mux_rr_arbiter with MAX_BURST=8.
module tb_mux_rr_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    mux_rr_arbiter_if bus ();

    mux_rr_arbiter #(.MAX_BURST(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                              input logic a, input logic [3:0] b);
        check({tag, ".grant"}, 8'(bus.grant), 8'(g));
        check({tag, ".sel"}, 8'(bus.sel), 8'(s));
        check({tag, ".active"}, 8'(bus.active), 8'(a));
        check({tag, ".burst"}, 8'(bus.burst_cnt), 8'(b));
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req  = '0;
        bus.done = '0;

        // Reset, then idle with no requests.
        rst = 1'b1;
        tick();
        tick();
        expect_out("reset", 4'b0000, 2'd0, 1'b0, 4'd0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_out("idle", 4'b0000, 2'd0, 1'b0, 4'd0);
        end

        // Single source 1, released by done when burst_cnt==3.
        bus.req = 4'b0010;
        tick();
        expect_out("s1.c1", 4'b0010, 2'd1, 1'b1, 4'd1);
        tick();
        expect_out("s1.c2", 4'b0010, 2'd1, 1'b1, 4'd2);
        tick();
        expect_out("s1.c3", 4'b0010, 2'd1, 1'b1, 4'd3);
        bus.done = 4'b0010;
        tick();
        expect_out("s1.rel", 4'b0000, 2'd1, 1'b0, 4'd0);
        bus.done = '0;
        bus.req  = '0;
        tick();
        expect_out("s1.idle", 4'b0000, 2'd1, 1'b0, 4'd0);

        // Done while idle is ignored.
        bus.done = 4'b1111;
        tick();
        expect_out("idle.done", 4'b0000, 2'd1, 1'b0, 4'd0);
        bus.done = '0;

        // ptr=2: source 2 owns, drops req; then 1011 picks source 3.
        bus.req = 4'b0100;
        tick();
        expect_out("s2.own", 4'b0100, 2'd2, 1'b1, 4'd1);
        bus.req = '0;
        tick();
        expect_out("s2.rel", 4'b0000, 2'd2, 1'b0, 4'd0);
        bus.req = 4'b1011;
        tick();
        expect_out("ptr3.win", 4'b1000, 2'd3, 1'b1, 4'd1);
        // done and req dropping together: one release.
        bus.req  = 4'b0011;
        bus.done = 4'b1000;
        tick();
        expect_out("s3.rel", 4'b0000, 2'd3, 1'b0, 4'd0);
        bus.req  = '0;
        bus.done = '0;
        tick();
        expect_out("s3.idle", 4'b0000, 2'd3, 1'b0, 4'd0);

        // ptr=0: all four requesting, forced release at 8 cycles each.
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            for (int c = 1; c <= 8; c++) begin
                expect_out($sformatf("rr%0d.c%0d", k, c), 4'(1 << (k % 4)), 2'(k % 4), 1'b1, 4'(c));
                if (c < 8) tick();
            end
            tick();
            if (k == 4) bus.req = '0;
            expect_out($sformatf("rr%0d.bubble", k), 4'b0000, 2'(k % 4), 1'b0, 4'd0);
        end
        tick();
        expect_out("rr.idle", 4'b0000, 2'd0, 1'b0, 4'd0);

        // ptr=1: source 0 owns; stray done on other bits ignored.
        bus.req = 4'b0001;
        tick();
        expect_out("stray.c1", 4'b0001, 2'd0, 1'b1, 4'd1);
        bus.done = 4'b1110;
        tick();
        expect_out("stray.c2", 4'b0001, 2'd0, 1'b1, 4'd2);
        tick();
        expect_out("stray.c3", 4'b0001, 2'd0, 1'b1, 4'd3);
        bus.done = '0;
        bus.req  = '0;
        tick();
        expect_out("stray.rel", 4'b0000, 2'd0, 1'b0, 4'd0);

        // Source 3 owns to burst_cnt=5, then reset mid-grant.
        bus.req = 4'b1000;
        tick();
        for (int c = 1; c <= 5; c++) begin
            expect_out($sformatf("mid.c%0d", c), 4'b1000, 2'd3, 1'b1, 4'(c));
            if (c < 5) tick();
        end
        rst = 1'b1;
        tick();
        expect_out("mid.rst", 4'b0000, 2'd0, 1'b0, 4'd0);
        rst = 1'b0;
        tick();
        expect_out("mid.regrant", 4'b1000, 2'd3, 1'b1, 4'd1);
        // ptr is 0 after reset: 1001 would pick source 0 after release.
        bus.req = 4'b0001;
        tick();
        expect_out("mid.rel", 4'b0000, 2'd3, 1'b0, 4'd0);
        bus.req = 4'b1001;
        tick();
        expect_out("mid.ptr0", 4'b0001, 2'd0, 1'b1, 4'd1);
        bus.req = '0;
        tick();
        expect_out("end.rel", 4'b0000, 2'd0, 1'b0, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
